// File: rtl/prog_rom_sequencer_if.sv
// Bus between the instruction sequencer and its users: the program-load
// port, run control, and the instruction handshake toward the CPU.
interface prog_rom_sequencer_if #(
    parameter int INST_W = 8,
    parameter int ADDR_W = 4
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [INST_W-1:0] prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              loop_en;
    logic              abort;
    logic              inst_done;
    logic [INST_W-1:0] rom_inst;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              rom_done;
    logic              prog_err;

    // Host/CPU side: drives program data, control and acknowledges
    modport master (
        output prog_we, prog_addr, prog_data, prog_len,
        output start, loop_en, abort, inst_done,
        input  rom_inst, inst_valid, pc, busy, rom_done, prog_err
    );

    // Sequencer side
    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len,
        input  start, loop_en, abort, inst_done,
        output rom_inst, inst_valid, pc, busy, rom_done, prog_err
    );
endinterface

// File: rtl/prog_rom_sequencer.sv
// Writable instruction store and sequencer for the 4-bit CPU. A program is
// loaded while not issuing, then a start pulse walks through prog_len slots,
// handing each instruction to the CPU with an inst_valid/inst_done handshake.
module prog_rom_sequencer #(
    parameter int                INST_W   = 8,
    parameter int                DEPTH    = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(8'b1000_0000)
) (
    input logic                  clk,
    input logic                  clr_n,
    prog_rom_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W:0]   len_q, len_nxt;
    logic              prog_err;
    logic [INST_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   len_clamp;
    logic              at_last;

    // Requested lengths beyond the store are clamped to its depth; the
    // last-slot compare is one bit wider than pc so a full-depth run matches.
    assign len_clamp = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
    assign at_last   = ({1'b0, pc} == (len_q - ONE_L));

    // Program store: writes land only when not issuing, so a running program never changes underneath the CPU
    always_ff @(posedge clk) begin
        if (bus.prog_we && (state != ISSUE)) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Sequencer state, program counter, latched length and the sticky write-while-busy flag
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            pc       <= '0;
            len_q    <= '0;
            prog_err <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            len_q <= len_nxt;
            if (bus.prog_we && (state == ISSUE)) begin
                prog_err <= 1'b1;
            end
        end
    end

    // Next-state logic: abort overrides everything, start is honoured from IDLE or DONE, inst_done only in ISSUE
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        len_nxt   = len_q;
        if (bus.abort) begin
            state_nxt = IDLE;
            pc_nxt    = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        len_nxt   = len_clamp;
                        pc_nxt    = '0;
                        state_nxt = (len_clamp == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.inst_done) begin
                        if (!at_last) begin
                            pc_nxt = pc + PC_ONE;
                        end else if (bus.loop_en) begin
                            pc_nxt = '0;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    pc_nxt    = '0;
                end
            endcase
        end
    end

    // Outputs decode from state alone, so an asynchronous reset clears them immediately
    always_comb begin
        bus.rom_inst   = NOP_INST;
        bus.inst_valid = 1'b0;
        bus.busy       = 1'b0;
        bus.rom_done   = 1'b0;
        case (state)
            ISSUE: begin
                bus.rom_inst   = mem[pc];
                bus.inst_valid = 1'b1;
                bus.busy       = 1'b1;
            end
            DONE: begin
                bus.rom_done = 1'b1;
            end
            default: begin
                bus.rom_inst = NOP_INST;
            end
        endcase
    end

    assign bus.pc       = pc;
    assign bus.prog_err = prog_err;

endmodule
